// File: rtl/alt_vipitc131_common_pkg.sv
// Shared constants and types for the clocked-video sync generator:
// default 1080p timing, region encodings and the timing-config record.
package alt_vipitc131_common_pkg;

    localparam int   DFLT_H_ACTIVE = 1920;
    localparam int   DFLT_H_FP     = 88;
    localparam int   DFLT_H_SYNC   = 44;
    localparam int   DFLT_H_BP     = 148;
    localparam int   DFLT_V_ACTIVE = 1080;
    localparam int   DFLT_V_FP     = 4;
    localparam int   DFLT_V_SYNC   = 5;
    localparam int   DFLT_V_BP     = 36;
    localparam logic DFLT_H_POL    = 1'b1;
    localparam logic DFLT_V_POL    = 1'b1;

    localparam logic [1:0] RGN_ACTIVE = 2'd0;
    localparam logic [1:0] RGN_FP     = 2'd1;
    localparam logic [1:0] RGN_SYNC   = 2'd2;
    localparam logic [1:0] RGN_BP     = 2'd3;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [14:0] v_active;
        logic [14:0] v_fp;
        logic [14:0] v_sync;
        logic [14:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } timing_cfg_t;

endpackage

// File: rtl/alt_vipitc131_common_sync_region.sv
// One-axis region decoder: classifies a count into active/fp/sync/bp and
// derives blank, polarity-adjusted sync and the axis total minus one.
module alt_vipitc131_common_sync_region
    import alt_vipitc131_common_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] active,
    input  logic [WIDTH-1:0] fp,
    input  logic [WIDTH-1:0] sync_width,
    input  logic [WIDTH-1:0] bp,
    input  logic             pol,
    output logic             blank,
    output logic             sync,
    output logic [WIDTH-1:0] total_m1
);
    // Edges are kept two bits wider so oversized porches cannot wrap the
    // range tests; only the reported total is truncated to WIDTH.
    localparam int EW = WIDTH + 2;

    logic [EW-1:0] fp_start, sync_start, bp_start, cnt_x;
    logic [1:0]    region;

    always_comb begin
        cnt_x      = EW'(count);
        fp_start   = EW'(active);
        sync_start = fp_start + EW'(fp);
        bp_start   = sync_start + EW'(sync_width);
        region     = RGN_BP;
        if (cnt_x < fp_start)        region = RGN_ACTIVE;
        else if (cnt_x < sync_start) region = RGN_FP;
        else if (cnt_x < bp_start)   region = RGN_SYNC;
    end

    assign blank    = (region != RGN_ACTIVE);
    assign sync     = (region == RGN_SYNC) ~^ pol;
    assign total_m1 = active + fp + sync_width + bp - WIDTH'(1);

endmodule

// File: rtl/alt_vipitc131_common_sync_generator.sv
// Timing decoder for the video output path: registers sync/blank/de/pulses
// from the frame counter position and shadows config changes to frame end.
module alt_vipitc131_common_sync_generator
    import alt_vipitc131_common_pkg::*;
#(
    parameter int DEF_H_ACTIVE = DFLT_H_ACTIVE,
    parameter int DEF_H_FP     = DFLT_H_FP,
    parameter int DEF_H_SYNC   = DFLT_H_SYNC,
    parameter int DEF_H_BP     = DFLT_H_BP,
    parameter int DEF_V_ACTIVE = DFLT_V_ACTIVE,
    parameter int DEF_V_FP     = DFLT_V_FP,
    parameter int DEF_V_SYNC   = DFLT_V_SYNC,
    parameter int DEF_V_BP     = DFLT_V_BP
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        sclr,
    input  logic        enable,
    input  logic [15:0] h_count,
    input  logic [14:0] v_count,
    input  logic        new_line,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_h_active,
    input  logic [15:0] cfg_h_fp,
    input  logic [15:0] cfg_h_sync,
    input  logic [15:0] cfg_h_bp,
    input  logic [14:0] cfg_v_active,
    input  logic [14:0] cfg_v_fp,
    input  logic [14:0] cfg_v_sync,
    input  logic [14:0] cfg_v_bp,
    input  logic        cfg_h_pol,
    input  logic        cfg_v_pol,
    output logic [15:0] h_total_m1,
    output logic [14:0] v_total_m1,
    output logic        h_sync,
    output logic        v_sync,
    output logic        h_blank,
    output logic        v_blank,
    output logic        de,
    output logic        sof,
    output logic        sol
);
    localparam timing_cfg_t DEF_CFG = '{
        h_active: 16'(DEF_H_ACTIVE), h_fp: 16'(DEF_H_FP),
        h_sync:   16'(DEF_H_SYNC),   h_bp: 16'(DEF_H_BP),
        v_active: 15'(DEF_V_ACTIVE), v_fp: 15'(DEF_V_FP),
        v_sync:   15'(DEF_V_SYNC),   v_bp: 15'(DEF_V_BP),
        h_pol:    DFLT_H_POL,        v_pol: DFLT_V_POL
    };
    localparam logic RST_H_SYNC = ~DFLT_H_POL;
    localparam logic RST_V_SYNC = ~DFLT_V_POL;

    timing_cfg_t act_q, act_d, stg_q, stg_d, cfg_in;
    logic        pend_q, pend_d;
    logic        h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic        h_blank_q, h_blank_d, v_blank_q, v_blank_d;
    logic        de_q, de_d, sof_q, sof_d, sol_q, sol_d;
    logic        h_sync_w, v_sync_w, h_blank_w, v_blank_w;
    logic        accept, apply_evt;

    assign cfg_in = '{
        h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
        v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
        h_pol: cfg_h_pol, v_pol: cfg_v_pol
    };

    alt_vipitc131_common_sync_region #(.WIDTH(16)) u_h_region (
        .count(h_count), .active(act_q.h_active), .fp(act_q.h_fp),
        .sync_width(act_q.h_sync), .bp(act_q.h_bp), .pol(act_q.h_pol),
        .blank(h_blank_w), .sync(h_sync_w), .total_m1(h_total_m1)
    );

    alt_vipitc131_common_sync_region #(.WIDTH(15)) u_v_region (
        .count(v_count), .active(act_q.v_active), .fp(act_q.v_fp),
        .sync_width(act_q.v_sync), .bp(act_q.v_bp), .pol(act_q.v_pol),
        .blank(v_blank_w), .sync(v_sync_w), .total_m1(v_total_m1)
    );

    assign cfg_ready = !pend_q;
    assign accept    = cfg_valid && cfg_ready;
    assign apply_evt = enable && new_line && (v_count >= v_total_m1);

    // Accept is only possible with nothing pending, so a same-cycle apply
    // never consumes the config being accepted.
    always_comb begin
        act_d  = act_q;
        stg_d  = stg_q;
        pend_d = pend_q;
        if ((sclr || apply_evt) && pend_q) begin
            act_d  = stg_q;
            pend_d = 1'b0;
        end
        if (accept) begin
            stg_d  = cfg_in;
            pend_d = 1'b1;
        end
    end

    always_comb begin
        h_sync_d  = h_sync_q;
        v_sync_d  = v_sync_q;
        h_blank_d = h_blank_q;
        v_blank_d = v_blank_q;
        de_d      = de_q;
        sof_d     = 1'b0;
        sol_d     = 1'b0;
        if (sclr) begin
            h_sync_d  = RST_H_SYNC;
            v_sync_d  = RST_V_SYNC;
            h_blank_d = 1'b1;
            v_blank_d = 1'b1;
            de_d      = 1'b0;
        end else if (enable) begin
            h_sync_d  = h_sync_w;
            v_sync_d  = v_sync_w;
            h_blank_d = h_blank_w;
            v_blank_d = v_blank_w;
            de_d      = !h_blank_w && !v_blank_w;
            sof_d     = (h_count == 16'd0) && (v_count == 15'd0);
            sol_d     = (h_count == 16'd0) && !v_blank_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q     <= DEF_CFG;
            stg_q     <= DEF_CFG;
            pend_q    <= 1'b0;
            h_sync_q  <= RST_H_SYNC;
            v_sync_q  <= RST_V_SYNC;
            h_blank_q <= 1'b1;
            v_blank_q <= 1'b1;
            de_q      <= 1'b0;
            sof_q     <= 1'b0;
            sol_q     <= 1'b0;
        end else begin
            act_q     <= act_d;
            stg_q     <= stg_d;
            pend_q    <= pend_d;
            h_sync_q  <= h_sync_d;
            v_sync_q  <= v_sync_d;
            h_blank_q <= h_blank_d;
            v_blank_q <= v_blank_d;
            de_q      <= de_d;
            sof_q     <= sof_d;
            sol_q     <= sol_d;
        end
    end

    assign h_sync  = h_sync_q;
    assign v_sync  = v_sync_q;
    assign h_blank = h_blank_q;
    assign v_blank = v_blank_q;
    assign de      = de_q;
    assign sof     = sof_q;
    assign sol     = sol_q;

endmodule

// File: tb/tb_alt_vipitc131_common_sync_generator.sv
// Directed bench for the sync generator: expected strobes are queued as counts
// are driven and popped one cycle later when the registered outputs appear.
module tb_alt_vipitc131_common_sync_generator;

    typedef struct packed {
        logic hs, vs, hb, vb, de, sof, sol;
    } out_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } mcfg_t;

    localparam out_t RST_OUT = '{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1,
                                 de: 1'b0, sof: 1'b0, sol: 1'b0};

    logic        rst, clk, sclr, enable, new_line, cfg_valid, cfg_ready;
    logic [15:0] h_count, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp, h_total_m1;
    logic [14:0] v_count, cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, v_total_m1;
    logic        cfg_h_pol, cfg_v_pol;
    logic        h_sync, v_sync, h_blank, v_blank, de, sof, sol;

    alt_vipitc131_common_sync_generator dut (
        .rst(rst), .clk(clk), .sclr(sclr), .enable(enable),
        .h_count(h_count), .v_count(v_count), .new_line(new_line),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp),
        .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp),
        .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
        .h_total_m1(h_total_m1), .v_total_m1(v_total_m1),
        .h_sync(h_sync), .v_sync(v_sync), .h_blank(h_blank), .v_blank(v_blank),
        .de(de), .sof(sof), .sol(sol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    out_t  sb[$];
    out_t  last;
    mcfg_t mc, mnext;
    bit    mpend;

    function automatic mcfg_t mk(int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb, bit hp, bit vp);
        mcfg_t c;
        c.ha = ha; c.hf = hf; c.hs = hs; c.hb = hb;
        c.va = va; c.vf = vf; c.vs = vs; c.vb = vb;
        c.hp = hp; c.vp = vp;
        return c;
    endfunction

    function automatic out_t decode(mcfg_t c, int h, int v);
        out_t o;
        bit   in_hs, in_vs;
        in_hs = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
        in_vs = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
        o.hs  = in_hs ? c.hp : !c.hp;
        o.vs  = in_vs ? c.vp : !c.vp;
        o.hb  = (h >= c.ha);
        o.vb  = (v >= c.va);
        o.de  = (h < c.ha) && (v < c.va);
        o.sof = (h == 0) && (v == 0);
        o.sol = (h == 0) && (v < c.va);
        return o;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_cfg(mcfg_t c);
        cfg_h_active = 16'(c.ha); cfg_h_fp = 16'(c.hf);
        cfg_h_sync   = 16'(c.hs); cfg_h_bp = 16'(c.hb);
        cfg_v_active = 15'(c.va); cfg_v_fp = 15'(c.vf);
        cfg_v_sync   = 15'(c.vs); cfg_v_bp = 15'(c.vb);
        cfg_h_pol    = c.hp;      cfg_v_pol = c.vp;
    endtask

    // One clock: drive counts, queue the expected strobes, compare after the edge.
    task automatic step(int h, int v, bit en, bit nl, bit sc = 1'b0);
        out_t e, o;
        h_count = 16'(h); v_count = 15'(v);
        enable = en; new_line = nl; sclr = sc;
        if (sc) e = RST_OUT;
        else if (en) e = decode(mc, h, v);
        else begin e = last; e.sof = 1'b0; e.sol = 1'b0; end
        last = e;
        sb.push_back(e);
        @(posedge clk); #1;
        o = '{hs: h_sync, vs: v_sync, hb: h_blank, vb: v_blank,
              de: de, sof: sof, sol: sol};
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk($sformatf("out h=%0d v=%0d", h, v), 32'(o), 32'(sb.pop_front()));
        sclr = 1'b0;
    endtask

    // Ideal frame counter over the current model config; on the last-line
    // wrap any pending config takes effect.
    task automatic run_frame(int hstep, bit half_en);
        int htot, vtot;
        bit en, nl;
        htot = mc.ha + mc.hf + mc.hs + mc.hb;
        vtot = mc.va + mc.vf + mc.vs + mc.vb;
        for (int v = 0; v < vtot; v++) begin
            for (int h = 0; h < htot; h += hstep) begin
                nl = (h + hstep >= htot);
                do begin
                    en = half_en ? 1'($urandom_range(0, 1)) : 1'b1;
                    step(h, v, en, nl);
                end while (!en);
                if (nl && v == vtot - 1 && mpend) begin
                    mc = mnext; mpend = 1'b0;
                end
            end
        end
    endtask

    int    pts_h [13] = '{0, 1919, 1920, 2007, 2008, 2051, 2052, 0, 0, 100, 100, 100, 100};
    int    pts_v [13] = '{0, 5,    5,    5,    5,    5,    5,    1079, 1080, 1083, 1084, 1088, 1089};
    int    vga_h [10] = '{639, 640, 655, 656, 751, 752, 10, 10, 10, 10};
    int    vga_v [10] = '{0,   0,   0,   0,   0,   0,   479, 490, 491, 492};
    mcfg_t DEF_M, VGA, SMALL, V2;
    int    de_cnt;

    initial begin
        DEF_M = mk(1920, 88, 44, 148, 1080, 4, 5, 36, 1, 1);
        VGA   = mk(640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
        SMALL = mk(12, 2, 3, 3, 6, 1, 1, 2, 1, 1);
        V2    = mk(10, 3, 5, 6, 4, 1, 1, 0, 0, 1);
        mc = DEF_M; mpend = 1'b0; last = RST_OUT;
        rst = 1'b1; sclr = 1'b0; enable = 1'b0; new_line = 1'b0;
        h_count = '0; v_count = '0; cfg_valid = 1'b0;
        drive_cfg(DEF_M);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out", 32'({h_sync, v_sync, h_blank, v_blank, de, sof, sol}), 32'(RST_OUT));
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_htot", 32'(h_total_m1), 32'd2199);
        chk("rst_vtot", 32'(v_total_m1), 32'd1124);

        // Default 1080p: sparse vertical points plus a full active line.
        for (int i = 0; i < 13; i++) step(pts_h[i], pts_v[i], 1'b1, 1'b0);
        step(5, 5, 1'b0, 1'b0);
        de_cnt = 0;
        for (int h = 0; h < 2200; h++) begin
            step(h, 5, 1'b1, h == 2199);
            if (de) de_cnt++;
        end
        chk("de_per_line", 32'(de_cnt), 32'd1920);
        for (int h = 2000; h < 2060; h++) step(h, 1084, 1'b1, 1'b0);

        // Reprogram to 640x480 mid-frame; applies on the last-line wrap.
        drive_cfg(VGA); cfg_valid = 1'b1;
        step(5, 10, 1'b1, 1'b0);
        cfg_valid = 1'b0; mnext = VGA; mpend = 1'b1;
        chk("vga_ready_low", 32'(cfg_ready), 32'd0);
        step(100, 600, 1'b1, 1'b0);
        step(2199, 1123, 1'b1, 1'b1);
        chk("vga_ready_hold", 32'(cfg_ready), 32'd0);
        chk("vga_htot_old", 32'(h_total_m1), 32'd2199);
        step(2199, 1124, 1'b1, 1'b1);
        mc = mnext; mpend = 1'b0;
        chk("vga_htot", 32'(h_total_m1), 32'd799);
        chk("vga_vtot", 32'(v_total_m1), 32'd524);
        chk("vga_ready_back", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 10; i++) step(vga_h[i], vga_v[i], 1'b1, 1'b0);

        // Back-to-back: second offer waits for cfg_ready.
        drive_cfg(SMALL); cfg_valid = 1'b1;
        step(0, 100, 1'b1, 1'b0);
        mnext = SMALL; mpend = 1'b1;
        drive_cfg(V2);
        step(1, 100, 1'b1, 1'b0);
        chk("b2b_held", 32'(cfg_ready), 32'd0);
        step(799, 524, 1'b1, 1'b1);
        mc = mnext; mpend = 1'b0;
        chk("b2b_ready", 32'(cfg_ready), 32'd1);
        chk("small_htot", 32'(h_total_m1), 32'd19);
        step(0, 0, 1'b1, 1'b0);
        cfg_valid = 1'b0; mnext = V2; mpend = 1'b1;
        chk("b2b_accepted", 32'(cfg_ready), 32'd0);
        run_frame(1, 1'b0);
        chk("v2_htot", 32'(h_total_m1), 32'd23);
        chk("v2_vtot", 32'(v_total_m1), 32'd5);
        chk("v2_ready", 32'(cfg_ready), 32'd1);

        // 50% enable, then 4-pixel stepping.
        run_frame(1, 1'b1);
        run_frame(4, 1'b0);

        // sclr applies a pending config at once and resets the strobes.
        drive_cfg(SMALL); cfg_valid = 1'b1;
        step(1, 1, 1'b1, 1'b0);
        cfg_valid = 1'b0; mnext = SMALL; mpend = 1'b1;
        step(2, 1, 1'b1, 1'b0, 1'b1);
        mc = mnext; mpend = 1'b0;
        chk("sclr_ready", 32'(cfg_ready), 32'd1);
        chk("sclr_htot", 32'(h_total_m1), 32'd19);
        chk("sclr_vtot", 32'(v_total_m1), 32'd9);
        step(0, 0, 1'b1, 1'b0);

        // rst mid-frame discards the pending config.
        drive_cfg(V2); cfg_valid = 1'b1;
        step(3, 2, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst2_htot", 32'(h_total_m1), 32'd2199);
        chk("rst2_vtot", 32'(v_total_m1), 32'd1124);
        chk("rst2_ready", 32'(cfg_ready), 32'd1);
        chk("rst2_out", 32'({h_sync, v_sync, h_blank, v_blank, de, sof, sol}), 32'(RST_OUT));
        rst = 1'b0;
        mc = DEF_M; mpend = 1'b0; last = RST_OUT;
        step(0, 0, 1'b1, 1'b0);
        step(2008, 1084, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
